// File: rtl/multi_oneshot_pkg.sv
// ============================================================================
// Module : multi_oneshot_pkg
// Brief  : Shared types and helpers for the multi-channel one-shot generator.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multi_oneshot_pkg;

   typedef enum logic [1:0] {
      OS_IDLE   = 2'd0,
      OS_ACTIVE = 2'd1,
      OS_HOLD   = 2'd2
   } os_state_t;

   localparam int c_max_num_ch = 16;

   // A programmed width of zero still yields a one-tick pulse.
   function automatic logic [31:0] os_load(input logic [31:0] width);
      return (width == 32'd0) ? 32'd1 : width;
   endfunction

endpackage

`default_nettype wire

// File: rtl/oneshot_channel.sv
// ============================================================================
// Module : oneshot_channel
// Brief  : Single one-shot channel: edge detect, pulse FSM, tick counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oneshot_channel
   import multi_oneshot_pkg::*;
#(
   parameter int WIDTH_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick_i,
   input  logic                  trig_n_i,
   input  logic                  edge_sel_i,
   input  logic                  retrig_en_i,
   input  logic [WIDTH_BITS-1:0] width_i,
   output logic                  pulse_o,
   output logic                  busy_o,
   output logic                  missed_o
);

   os_state_t             state_q, state_d;
   logic [WIDTH_BITS-1:0] cnt_q, cnt_d;
   logic                  trig_q;
   logic                  pulse_q, pulse_d;
   logic                  busy_q, busy_d;
   logic                  missed_q, missed_d;
   logic [WIDTH_BITS-1:0] w_load;
   logic                  w_edge;
   logic                  w_active;

   assign w_load   = WIDTH_BITS'(os_load(32'(width_i)));
   assign w_edge   = edge_sel_i ? (~trig_q & trig_n_i) : (trig_q & ~trig_n_i);
   assign w_active = edge_sel_i ? trig_n_i : ~trig_n_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= OS_IDLE;
         cnt_q    <= '0;
         trig_q   <= 1'b1;
         pulse_q  <= 1'b0;
         busy_q   <= 1'b0;
         missed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         trig_q   <= trig_n_i;
         pulse_q  <= pulse_d;
         busy_q   <= busy_d;
         missed_q <= missed_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      missed_d = 1'b0;
      case (state_q)
         OS_IDLE: begin
            if (w_edge) begin
               state_d = OS_ACTIVE;
               cnt_d   = w_load;
            end
         end
         OS_ACTIVE: begin
            // A retrigger reload takes priority over an end-of-count tick.
            if (w_edge && retrig_en_i) begin
               cnt_d = w_load;
            end else begin
               missed_d = w_edge;
               if (tick_i) begin
                  if (cnt_q > WIDTH_BITS'(1)) begin
                     cnt_d = cnt_q - WIDTH_BITS'(1);
                  end else begin
                     state_d = w_active ? OS_HOLD : OS_IDLE;
                  end
               end
            end
         end
         OS_HOLD: begin
            missed_d = w_edge;
            if (!w_active) begin
               state_d = OS_IDLE;
            end
         end
         default: begin
            state_d = OS_IDLE;
         end
      endcase
      pulse_d = (state_d == OS_ACTIVE);
      busy_d  = (state_d != OS_IDLE);
   end

   assign pulse_o  = pulse_q;
   assign busy_o   = busy_q;
   assign missed_o = missed_q;

endmodule

`default_nettype wire

// File: rtl/multi_oneshot_pulse.sv
// ============================================================================
// Module : multi_oneshot_pulse
// Brief  : NUM_CH independent one-shot pulse generators on a shared timebase.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_oneshot_pulse
   import multi_oneshot_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int WIDTH_BITS     = 8,
   parameter int RETRIG_DEFAULT = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         tick,
   input  logic [NUM_CH-1:0]            trigger_n,
   input  logic [NUM_CH-1:0]            edge_sel,
   input  logic [NUM_CH-1:0]            retrig_en,
   input  logic [NUM_CH*WIDTH_BITS-1:0] width_cfg,
   output logic [NUM_CH-1:0]            pulse,
   output logic [NUM_CH-1:0]            busy,
   output logic [NUM_CH-1:0]            missed_evt
);

   if ((NUM_CH < 1) || (NUM_CH > c_max_num_ch) ||
       (RETRIG_DEFAULT < 0) || (RETRIG_DEFAULT > 1)) begin : g_bad_param
      $error("multi_oneshot_pulse: parameter out of range");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      oneshot_channel #(
         .WIDTH_BITS (WIDTH_BITS)
      ) u_chan (
         .clk         (clk),
         .rst_n       (rst_n),
         .tick_i      (tick),
         .trig_n_i    (trigger_n[i]),
         .edge_sel_i  (edge_sel[i]),
         .retrig_en_i (retrig_en[i]),
         .width_i     (width_cfg[i*WIDTH_BITS +: WIDTH_BITS]),
         .pulse_o     (pulse[i]),
         .busy_o      (busy[i]),
         .missed_o    (missed_evt[i])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_multi_oneshot_pulse.sv
// ============================================================================
// Module : tb_multi_oneshot_pulse
// Brief  : Scoreboard bench for multi_oneshot_pulse with a behavioural model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_oneshot_pulse;

   localparam int NUM_CH = 4;
   localparam int WB     = 8;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 tick;
   logic [NUM_CH-1:0]    trigger_n, edge_sel, retrig_en;
   logic [NUM_CH*WB-1:0] width_cfg;
   logic [NUM_CH-1:0]    pulse, busy, missed_evt;

   always #5 clk = ~clk;

   multi_oneshot_pulse #(
      .NUM_CH         (NUM_CH),
      .WIDTH_BITS     (WB),
      .RETRIG_DEFAULT (0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .trigger_n  (trigger_n),
      .edge_sel   (edge_sel),
      .retrig_en  (retrig_en),
      .width_cfg  (width_cfg),
      .pulse      (pulse),
      .busy       (busy),
      .missed_evt (missed_evt)
   );

   typedef struct packed {
      logic [NUM_CH-1:0] p;
      logic [NUM_CH-1:0] b;
      logic [NUM_CH-1:0] m;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Model: per channel, mode 0 = waiting, 1 = pulsing, 2 = held after pulse.
   int   mode[NUM_CH];
   int   ticks_left[NUM_CH];
   bit   prev_trig[NUM_CH];
   int   tick_per   = 1;
   int   tick_phase = 0;

   // Apply the currently driven inputs to the model, queue the outputs the
   // DUT must show after the next clock edge, then advance one cycle.
   task automatic step();
      exp_t e;
      int   w;
      bit   trg, ev, act, miss;
      tick = ((tick_phase % tick_per) == 0);
      tick_phase++;
      e = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         miss = 1'b0;
         if (!rst_n) begin
            mode[ch]       = 0;
            ticks_left[ch] = 0;
            prev_trig[ch]  = 1'b1;
         end else begin
            trg = trigger_n[ch];
            ev  = edge_sel[ch] ? (!prev_trig[ch] && trg) : (prev_trig[ch] && !trg);
            act = edge_sel[ch] ? trg : !trg;
            w   = int'(width_cfg[ch*WB +: WB]);
            if (w == 0) w = 1;
            if (mode[ch] == 0) begin
               if (ev) begin
                  mode[ch]       = 1;
                  ticks_left[ch] = w;
               end
            end else if (mode[ch] == 1) begin
               if (ev && retrig_en[ch]) begin
                  ticks_left[ch] = w;
               end else begin
                  miss = ev;
                  if (tick) begin
                     ticks_left[ch] = ticks_left[ch] - 1;
                     if (ticks_left[ch] == 0) mode[ch] = act ? 2 : 0;
                  end
               end
            end else begin
               miss = ev;
               if (!act) mode[ch] = 0;
            end
            prev_trig[ch] = trg;
         end
         e.p[ch] = (mode[ch] == 1);
         e.b[ch] = (mode[ch] != 0);
         e.m[ch] = miss;
      end
      q.push_back(e);
      @(posedge clk);
      #3;
   endtask

   task automatic set_w(input int ch, input int val);
      width_cfg[ch*WB +: WB] = WB'(val);
   endtask

   task automatic do_reset(input int ncyc);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pulse, busy, missed_evt} !== '0) begin
         errors++;
         $display("FAIL async_reset t=%0t actual p=%b b=%b m=%b required all zero",
                  $time, pulse, busy, missed_evt);
      end
      repeat (ncyc) step();
      rst_n = 1'b1;
   endtask

   always @(posedge clk) begin
      #2;
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         checks++;
         if ({pulse, busy, missed_evt} !== mon_e) begin
            errors++;
            $display("FAIL outputs t=%0t actual p=%b b=%b m=%b required p=%b b=%b m=%b",
                     $time, pulse, busy, missed_evt, mon_e.p, mon_e.b, mon_e.m);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t actual timeout required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      tick      = 1'b1;
      trigger_n = '1;
      edge_sel  = '0;
      retrig_en = '0;
      width_cfg = '0;
      #1;
      checks++;
      if ({pulse, busy, missed_evt} !== '0) begin
         errors++;
         $display("FAIL reset_state actual p=%b b=%b m=%b required all zero",
                  pulse, busy, missed_evt);
      end
      step();
      step();
      rst_n = 1'b1;

      // Basic falling-edge pulse, trigger released early.
      set_w(0, 5);
      step();
      trigger_n[0] = 1'b0; step(); step();
      trigger_n[0] = 1'b1; repeat (8) step();

      // Slow timebase, trigger held: pulse then hold until release.
      tick_per = 4; tick_phase = 1;
      set_w(0, 3);
      trigger_n[0] = 1'b0; repeat (40) step();
      trigger_n[0] = 1'b1; repeat (4) step();
      tick_per = 1;

      // Retrigger enabled then disabled, second edge 4 clocks into pulse.
      set_w(0, 6);
      for (int r = 1; r >= 0; r--) begin
         retrig_en[0] = r[0];
         trigger_n[0] = 1'b0; step();
         trigger_n[0] = 1'b1; repeat (3) step();
         trigger_n[0] = 1'b0; step();
         trigger_n[0] = 1'b1; repeat (12) step();
      end

      // Rising-edge channel with zero width.
      edge_sel[2] = 1'b1;
      set_w(2, 0);
      step();
      trigger_n[2] = 1'b0; step(); step();
      trigger_n[2] = 1'b1; repeat (3) step();
      trigger_n[2] = 1'b0; step(); step();
      edge_sel[2] = 1'b0; step();
      trigger_n[2] = 1'b1; step(); step();

      // Reset mid-pulse, trigger idle at release.
      set_w(0, 5);
      trigger_n[0] = 1'b0; step();
      trigger_n[0] = 1'b1; step(); step();
      do_reset(2);
      repeat (6) step();

      // Reset mid-pulse, trigger still low at release.
      trigger_n[0] = 1'b0; step(); step(); step();
      do_reset(1);
      repeat (8) step();
      trigger_n[0] = 1'b1; repeat (3) step();

      // Randomised traffic on all channels.
      for (int c = 0; c < 3000; c++) begin
         if ((c % 200) == 0) tick_per = int'($urandom_range(1, 4));
         if ((c % 50) == 0) retrig_en = NUM_CH'($urandom);
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if ($urandom_range(0, 5) == 0) trigger_n[ch] = ~trigger_n[ch];
            if ($urandom_range(0, 199) == 0) edge_sel[ch] = ~edge_sel[ch];
            if ($urandom_range(0, 19) == 0) set_w(ch, int'($urandom_range(0, 6)));
         end
         if ($urandom_range(0, 399) == 0) do_reset(int'($urandom_range(1, 3)));
         step();
      end

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain actual %0d pending required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
